// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU encodings -- rounding modes, exponent limits,
// IEEE-754 constants and fflags bit positions.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    SPC_NONE = 2'b00,
    SPC_INF  = 2'b01,
    SPC_QNAN = 2'b10
  } special_e;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

  // fflags = {NV, DZ, OF, UF, NX}
  localparam int unsigned FF_NX = 0;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_NV = 4;

endpackage

// File: rtl/fpu_round_inc.sv
// fpu_round_inc: combinational round-up decision from the rounding mode,
// result sign and the lsb/guard/round/sticky bits. Shared with the
// conversion unit.
module fpu_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic       inc
);

  logic inexact;

  // Select the increment rule; reserved mode codes fall back to RNE
  always_comb begin
    inexact = g | r | s;
    inc     = 1'b0;
    case (rm_e'(rm))
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = !sign & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalizes the unrounded single-precision result using the
// leading-one position, aligns subnormals, rounds per rm and produces the
// IEEE-754 word with fflags through a 2-stage valid/ready pipeline.
// Optional: define FPU_NR_SPECIALS_EN to pass inf/qNaN through in_special.
module fpu_norm_round
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned MANT_W = 28
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [4:0]        in_lead,
  input  logic [2:0]        in_rm,
  input  logic [1:0]        in_special,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [4:0]        out_fflags
);

  // One extra bit so exponent adjustments never wrap
  localparam int unsigned EW = EXP_W + 1;

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // ---------------- stage 1: normalize / subnormal align ----------------
  logic [EW-1:0]     e_in, e_norm, e_align, rshift;
  logic [MANT_W-1:0] m_norm, m_align, lost_mask;
  logic [4:0]        lshift, rsh_sat;
  logic              tiny_n;

  // Put the leading one at bit 26, then denormalize if the exponent underflows
  always_comb begin
    e_in   = {in_exp[EXP_W-1], in_exp};
    m_norm = in_mant;
    e_norm = e_in;
    lshift = '0;
    if (in_lead == 5'd27) begin
      m_norm = {1'b0, in_mant[MANT_W-1:2], |in_mant[1:0]};
      e_norm = e_in + EW'(1);
    end else if (in_lead < 5'd26) begin
      lshift = 5'd26 - in_lead;
      m_norm = in_mant << lshift;
      e_norm = e_in - EW'(lshift);
    end
    tiny_n    = e_norm[EW-1] || (e_norm == '0);
    rshift    = EW'(1) - e_norm;
    // Shifts of 27 or more leave only sticky information
    rsh_sat   = ((rshift[EW-1:5] != '0) || (rshift[4:0] > 5'd27)) ? 5'd27 : rshift[4:0];
    lost_mask = ~({MANT_W{1'b1}} << rsh_sat);
    m_align   = m_norm;
    e_align   = e_norm;
    if (tiny_n) begin
      m_align = (m_norm >> rsh_sat) | MANT_W'(|(m_norm & lost_mask));
      e_align = '0;
    end
  end

  logic              s1_sign, s1_tiny, s1_zero;
  logic [EW-1:0]     s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic [2:0]        s1_rm;

  // Stage 1 register: capture the aligned operand when stage 1 can advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_tiny  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_rm    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_tiny <= tiny_n;
        s1_zero <= (in_mant == '0);
        s1_exp  <= e_align;
        s1_mant <= m_align;
        s1_rm   <= in_rm;
      end
    end
  end

`ifdef FPU_NR_SPECIALS_EN
  logic [1:0] s1_special;

  // Special-value tag travels alongside the operand
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_special <= '0;
    end else if (s1_adv && in_valid) begin
      s1_special <= in_special;
    end
  end
`endif

  // ---------------- stage 2: round and pack ----------------
  logic          inc, inexact, ovf, to_inf;
  logic [24:0]   sum;
  logic [EW-1:0] exp_r;
  logic [22:0]   frac;
  logic [31:0]   res_n;
  logic [4:0]    fl_n;

  fpu_round_inc u_round_inc (
    .rm   (s1_rm),
    .sign (s1_sign),
    .lsb  (s1_mant[3]),
    .g    (s1_mant[2]),
    .r    (s1_mant[1]),
    .s    (s1_mant[0]),
    .inc  (inc)
  );

  // Apply the increment, resolve carry/overflow and assemble result and flags
  always_comb begin
    inexact = |s1_mant[2:0];
    sum     = {1'b0, s1_mant[26:3]} + 25'(inc);
    exp_r   = s1_exp;
    frac    = sum[22:0];
    if (s1_tiny) begin
      // A carry into bit 23 turns the subnormal into the minimum normal
      exp_r = EW'(sum[23]);
    end else if (sum[24]) begin
      exp_r = s1_exp + EW'(1);
      frac  = sum[23:1];
    end
    ovf    = !s1_tiny && (exp_r >= EW'(EXP_MAX));
    to_inf = 1'b1;
    case (rm_e'(s1_rm))
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s1_sign;
      RM_RUP:  to_inf = !s1_sign;
      default: to_inf = 1'b1;
    endcase
    res_n        = {s1_sign, exp_r[7:0], frac};
    fl_n         = '0;
    fl_n[FF_NV]  = 1'b0;
    fl_n[FF_DZ]  = 1'b0;
    fl_n[FF_OF]  = ovf;
    fl_n[FF_UF]  = s1_tiny & inexact;
    fl_n[FF_NX]  = inexact | ovf;
    if (ovf) begin
      res_n = {s1_sign, to_inf ? POS_INF[30:0] : MAX_FINITE};
    end
    if (s1_zero) begin
      res_n = {s1_sign, 31'b0};
      fl_n  = '0;
    end
`ifdef FPU_NR_SPECIALS_EN
    if (special_e'(s1_special) == SPC_INF) begin
      res_n = {s1_sign, POS_INF[30:0]};
      fl_n  = '0;
    end else if (special_e'(s1_special) == SPC_QNAN) begin
      res_n = CANON_NAN;
      fl_n  = '0;
    end
`endif
  end

  // Stage 2 register: output holds until the consumer accepts it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_fflags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_n;
        out_fflags <= fl_n;
      end
    end
  end

  logic unused_bits;
`ifdef FPU_NR_SPECIALS_EN
  assign unused_bits = s1_mant[MANT_W-1];
`else
  assign unused_bits = s1_mant[MANT_W-1] ^ (^in_special);
`endif

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: self-checking bench for fpu_norm_round against a
// value-level rounding model (exact integer scaling, no GRS pipeline).
module tb_fpu_norm_round;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic [4:0]  in_lead;
  logic [2:0]  in_rm;
  logic [1:0]  in_special;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_norm_round #(.EXP_W(10), .MANT_W(28)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_lead    (in_lead),
    .in_rm      (in_rm),
    .in_special (in_special),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_fflags (out_fflags)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lead_of(input logic [27:0] m);
    for (int i = 27; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  // Value = m * 2^(e-153). Quantize to the target ulp exponent and round.
  function automatic void model(input logic s, input int e, input logic [27:0] m,
                                input logic [2:0] rm, output logic [31:0] res,
                                output logic [4:0] fl);
    longint bige, q, rem, half, mag, d, qexp, one;
    logic tiny, inexact, gt, eq, inc, ovf, to_inf;
    one = 1;
    res = {s, 31'b0};
    fl  = '0;
    if (m == 0) return;
    bige    = longint'(e) - 127 + lead_of(m) - 26;
    tiny    = (bige + 127) <= 0;
    qexp    = tiny ? -149 : bige - 23;
    d       = qexp - (longint'(e) - 153);
    inexact = 1'b0; gt = 1'b0; eq = 1'b0;
    if (d <= 0) begin
      q = longint'(m) << (-d);
    end else if (d >= 40) begin
      q = 0;
      inexact = 1'b1;
    end else begin
      q       = longint'(m) >> d;
      rem     = longint'(m) & ((one << d) - 1);
      half    = one << (d - 1);
      inexact = rem != 0;
      gt      = rem > half;
      eq      = rem == half;
    end
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & inexact;
      3'd3:    inc = !s & inexact;
      3'd4:    inc = gt | eq;
      default: inc = gt | (eq & q[0]);
    endcase
    q   = q + longint'(inc);
    mag = tiny ? q : (bige + 127) * 8388608 + q - 8388608;
    ovf = mag >= 64'h7F80_0000;
    if (ovf) begin
      case (rm)
        3'd1:    to_inf = 1'b0;
        3'd2:    to_inf = s;
        3'd3:    to_inf = !s;
        default: to_inf = 1'b1;
      endcase
      mag = to_inf ? 64'h7F80_0000 : 64'h7F7F_FFFF;
    end
    res = {s, mag[30:0]};
    fl  = {2'b00, ovf, tiny & inexact, inexact | ovf};
  endfunction

  // Single operation into an idle pipeline; returns result and latency
  task automatic run_op(input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic [2:0] rm, output logic [31:0] res,
                        output logic [4:0] fl, output int lat);
    in_sign = s; in_exp = e; in_mant = m; in_lead = 5'(lead_of(m)); in_rm = rm;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    fl  = out_fflags;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_special = 2'b00;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_lead = '0; in_rm = '0;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
    n_checks++; if (out_fflags !== 5'h0) begin n_fail++; $display("FAIL reset_out_fflags: got %h expected 00", out_fflags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [27:0] m;
    logic [2:0]  rm;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;

  task automatic test_directed();
    vec_t vq[$];
    logic [31:0] res;
    logic [4:0]  fl;
    int lat;
    vq.push_back('{1'b0, 10'd127,     28'h4000000, 3'd0, 32'h3F800000, 5'h00});
    vq.push_back('{1'b0, 10'd127,     28'h8000000, 3'd0, 32'h40000000, 5'h00});
    vq.push_back('{1'b0, 10'd127,     28'h7FFFFFC, 3'd0, 32'h40000000, 5'h01});
    vq.push_back('{1'b0, 10'd150,     28'h0000008, 3'd0, 32'h3F800000, 5'h00});
    vq.push_back('{1'b1, 10'd127,     28'h0000000, 3'd0, 32'h80000000, 5'h00});
    vq.push_back('{1'b0, 10'd254,     28'h8000000, 3'd0, 32'h7F800000, 5'h05});
    vq.push_back('{1'b0, 10'd254,     28'h8000000, 3'd1, 32'h7F7FFFFF, 5'h05});
    vq.push_back('{1'b1, 10'd254,     28'h8000000, 3'd2, 32'hFF800000, 5'h05});
    vq.push_back('{1'b0, 10'h3FF,     28'h4000000, 3'd0, 32'h00200000, 5'h00});
    vq.push_back('{1'b0, 10'h3FF,     28'h4000001, 3'd0, 32'h00200000, 5'h03});
    vq.push_back('{1'b0, 10'h270,     28'h4000000, 3'd3, 32'h00000001, 5'h03});
    vq.push_back('{1'b0, 10'd0,       28'h7FFFFFF, 3'd0, 32'h00800000, 5'h03});
    vq.push_back('{1'b0, 10'd127,     28'h7FFFFFC, 3'd5, 32'h40000000, 5'h01});
    vq.push_back('{1'b0, 10'd127,     28'h4000004, 3'd0, 32'h3F800000, 5'h01});
    vq.push_back('{1'b0, 10'd127,     28'h400000C, 3'd0, 32'h3F800002, 5'h01});
    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].s, vq[i].e, vq[i].m, vq[i].rm, res, fl, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 2", i, lat); end
      n_checks++; if (res !== vq[i].r) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vq[i].r); end
      n_checks++; if (fl !== vq[i].f) begin n_fail++; $display("FAIL directed_fflags[%0d]: got %h expected %h", i, fl, vq[i].f); end
    end
  endtask

  function automatic int rand_exp();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1023)) - 512;
      1:       return 127 + int'($urandom_range(0, 80)) - 40;
      2:       return 230 + int'($urandom_range(0, 40));
      default: return int'($urandom_range(0, 40)) - 34;
    endcase
  endfunction

  function automatic logic [27:0] rand_mant();
    int ld;
    logic [27:0] lowmask, one28;
    if ($urandom_range(0, 15) == 0) return '0;
    ld      = $urandom_range(0, 27);
    one28   = 28'd1;
    lowmask = (one28 << ld) - one28;
    return (28'($urandom) & lowmask) | (one28 << ld);
  endfunction

  // Random traffic with random backpressure against a scoreboard queue
  task automatic test_random(input int n_ops);
    logic [36:0] exq[$];
    logic [36:0] pend, want;
    logic [31:0] ores, mres, hres;
    logic [4:0]  ofl, mfl, hfl;
    logic fin, fout, held;
    int sent = 0, recv = 0, cyc = 0, e;
    held = 1'b0; hres = '0; hfl = '0; pend = '0;
    while (recv < n_ops && cyc < n_ops * 20) begin
      if (sent < n_ops) in_valid = ($urandom_range(0, 3) != 0);
      else in_valid = 1'b0;
      e = rand_exp();
      in_sign = 1'($urandom); in_exp = 10'(e); in_mant = rand_mant();
      in_lead = 5'(lead_of(in_mant)); in_rm = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== hres || out_fflags !== hfl) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b %h/%h expected v=1 %h/%h", out_valid, out_result, out_fflags, hres, hfl);
        end
      end
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      held = out_valid && !out_ready;
      ores = out_result; ofl = out_fflags; hres = out_result; hfl = out_fflags;
      if (fin) begin
        model(in_sign, e, in_mant, in_rm, mres, mfl);
        pend = {mres, mfl};
      end
      @(posedge clk); #1;
      cyc++;
      if (fout) begin
        recv++;
        n_checks++;
        if (exq.size() == 0) begin
          n_fail++;
          $display("FAIL random_unexpected: got %h/%h expected no output", ores, ofl);
        end else begin
          want = exq.pop_front();
          if ({ores, ofl} !== want) begin
            n_fail++;
            $display("FAIL random_result: got %h/%h expected %h/%h", ores, ofl, want[36:5], want[4:0]);
          end
        end
      end
      if (fin) begin
        exq.push_back(pend);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (recv != n_ops) begin n_fail++; $display("FAIL random_timeout: got %0d outputs expected %0d", recv, n_ops); end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Four ops with the consumer stalled for the first three cycles
  task automatic test_backpressure();
    logic [36:0] exq[$];
    logic [36:0] want;
    logic [31:0] ores, mres;
    logic [4:0]  ofl, mfl;
    logic [27:0] mants [4];
    logic fin, fout;
    int k = 0, recv = 0;
    mants[0] = 28'h4000000; mants[1] = 28'h5800000; mants[2] = 28'h6C00000; mants[3] = 28'h7A00003;
    for (int c = 0; c < 30 && recv < 4; c++) begin
      out_ready = (c >= 3);
      in_valid  = (k < 4);
      in_sign = 1'b0; in_exp = 10'd127 + 10'(k); in_mant = mants[k % 4];
      in_lead = 5'(lead_of(in_mant)); in_rm = 3'd0;
      #2;
      if (c == 1) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one_buffered: got %b expected 1", in_ready); end
      end
      if (c == 2) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two_buffered: got %b expected 0", in_ready); end
      end
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      ores = out_result; ofl = out_fflags;
      if (fin) model(in_sign, int'(in_exp), in_mant, in_rm, mres, mfl);
      @(posedge clk); #1;
      if (fout) begin
        recv++;
        n_checks++;
        want = (exq.size() != 0) ? exq.pop_front() : '1;
        if ({ores, ofl} !== want) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got %h/%h expected %h/%h", recv - 1, ores, ofl, want[36:5], want[4:0]);
        end
      end
      if (fin) begin
        exq.push_back({mres, mfl});
        k++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (recv != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", recv); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] res;
    logic [4:0]  fl;
    int lat;
    out_ready = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_rm = 3'd0;
    in_mant = 28'h4000000; in_lead = 5'd26; in_valid = 1'b1;
    @(posedge clk); #1;
    in_mant = 28'h5000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL mid_reset_result: got %h expected 00000000", out_result); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_out[%0d]: got %b expected 0", i, out_valid); end
    end
    run_op(1'b1, 10'd128, 28'h6000000, 3'd0, res, fl, lat);
    n_checks++; if (res !== 32'hC0400000 || fl !== 5'h00 || lat !== 2) begin
      n_fail++; $display("FAIL mid_recover: got %h/%h lat %0d expected c0400000/00 lat 2", res, fl, lat);
    end
  endtask

`ifdef FPU_NR_SPECIALS_EN
  task automatic test_specials();
    logic [31:0] res;
    logic [4:0]  fl;
    int lat;
    in_special = 2'b01;
    run_op(1'b1, 10'd127, 28'h4000001, 3'd0, res, fl, lat);
    n_checks++; if (res !== 32'hFF800000 || fl !== 5'h00 || lat !== 2) begin
      n_fail++; $display("FAIL special_inf: got %h/%h lat %0d expected ff800000/00 lat 2", res, fl, lat);
    end
    in_special = 2'b10;
    run_op(1'b0, 10'd254, 28'h8000000, 3'd0, res, fl, lat);
    n_checks++; if (res !== 32'h7FC00000 || fl !== 5'h00 || lat !== 2) begin
      n_fail++; $display("FAIL special_nan: got %h/%h lat %0d expected 7fc00000/00 lat 2", res, fl, lat);
    end
    in_special = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(400);
    test_reset_midstream();
`ifdef FPU_NR_SPECIALS_EN
    test_specials();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
